// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: multi-cycle RV32I control FSM with memory handshake and trapping.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   opcode          IR[6:0], captured in DECODE
//   mem_ready       memory completes the current request (FETCH/MEM only)
//   trap_clear      leave TRAP (ignored elsewhere)
//   mem_req, i_or_d, mem_read, mem_write, ir_write       memory port / IR control
//   pc_write, branch, jump, reg_write, mem_to_reg, alu_src, alu_op   datapath control
//   trap, trap_cause, state_dbg                          status
module riscv_multicycle_control #(
    parameter int ALUOP_W         = 2,
    parameter int MEM_TIMEOUT     = 15,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    input  logic               trap_clear,
    output logic               mem_req,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic               jump,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [2:0]         state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter only needs to reach MEM_TIMEOUT; keep one bit when the timeout is disabled.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    function automatic logic legal(input logic [6:0] o);
        return o == OP_R || o == OP_I || o == OP_LOAD || o == OP_STORE || o == OP_BRANCH ||
               o == OP_LUI || o == OP_AUIPC || o == OP_JAL || o == OP_JALR;
    endfunction

    state_t          state, state_next;
    logic [6:0]      opcode_q;
    logic [CW-1:0]   cnt;
    logic [1:0]      cause_next;
    logic            timeout;
    logic            is_load, is_store, is_jump, is_branch;
    logic [2:0]      aop;

    assign is_load   = opcode_q == OP_LOAD;
    assign is_store  = opcode_q == OP_STORE;
    assign is_branch = opcode_q == OP_BRANCH;
    assign is_jump   = opcode_q == OP_JAL || opcode_q == OP_JALR;
    assign timeout   = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            opcode_q   <= '0;
            cnt        <= '0;
            trap_cause <= 2'b00;
        end else begin
            state      <= state_next;
            trap_cause <= cause_next;
            opcode_q   <= (state == S_DECODE) ? opcode : opcode_q;
            // Counts waiting cycles; any state change (including entry) restarts it.
            cnt        <= (state_next == state && (state == S_FETCH || state == S_MEM)) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state;
        cause_next = trap_cause;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
                else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = 2'b10;
                end
            end
            S_DECODE: begin
                if (TRAP_ON_ILLEGAL != 0 && !legal(opcode)) begin
                    state_next = S_TRAP;
                    cause_next = 2'b01;
                end else state_next = S_EXEC;
            end
            S_EXEC:   state_next = (is_branch || is_jump) ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) state_next = is_load ? S_WB : S_FETCH;
                else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = 2'b11;
                end
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP: begin
                if (trap_clear) begin
                    state_next = S_FETCH;
                    cause_next = 2'b00;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = state == S_FETCH || state == S_MEM;
        i_or_d     = state == S_MEM;
        mem_read   = state == S_FETCH || (state == S_MEM && is_load);
        mem_write  = state == S_MEM && is_store;
        ir_write   = state == S_FETCH && mem_ready;
        branch     = state == S_EXEC && is_branch;
        jump       = state == S_EXEC && is_jump;
        pc_write   = (state == S_EXEC && is_jump) || (state == S_MEM && is_store && mem_ready) || state == S_WB;
        reg_write  = (state == S_EXEC && is_jump) || (state == S_WB && legal(opcode_q));
        mem_to_reg = state == S_WB && is_load;
        alu_src    = state == S_MEM || (state == S_EXEC && (is_load || is_store || opcode_q == OP_I ||
                     opcode_q == OP_LUI || opcode_q == OP_AUIPC || opcode_q == OP_JALR));
        // Bit 2 flags immediate arithmetic; it is dropped when alu_op is only two bits wide.
        aop        = state == S_MEM ? 3'b010 :
                     state != S_EXEC ? 3'b000 :
                     opcode_q == OP_R ? 3'b000 :
                     opcode_q == OP_I ? 3'b100 :
                     is_branch ? 3'b001 : 3'b010;
        alu_op     = ALUOP_W'(aop);
        trap       = state == S_TRAP;
        state_dbg  = state;
    end
endmodule

// File: tb/tb_riscv_multicycle_control.sv
// tb_riscv_multicycle_control: directed self-checking bench for riscv_multicycle_control.
module tb_riscv_multicycle_control;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] opcode = 7'h00;
    logic       mem_ready = 1'b0, trap_clear = 1'b0;
    logic       mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, branch, jump;
    logic       reg_write, mem_to_reg, alu_src, trap;
    logic [1:0] alu_op, trap_cause;
    logic [2:0] state_dbg;
    logic [10:0] ctl;
    int checks = 0, failures = 0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;
    // {mem_req,i_or_d,mem_read,mem_write,ir_write,pc_write,branch,jump,reg_write,mem_to_reg,alu_src}
    localparam logic [10:0] F0 = 11'b10100000000, F1 = 11'b10101000000;
    localparam logic [10:0] WB_R = 11'b00000100100, WB_LD = 11'b00000100110, EX_LS = 11'b00000000001;
    localparam logic [10:0] MEM_LD = 11'b11100000001, MEM_ST = 11'b11010000001, MEM_ST_R = 11'b11010100001;
    localparam logic [10:0] EX_BR = 11'b00000010000, EX_JAL = 11'b00000101100;

    always #5 clk = ~clk;

    assign ctl = {mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, branch, jump, reg_write, mem_to_reg, alu_src};

    riscv_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .trap_clear(trap_clear),
        .mem_req(mem_req), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .jump(jump),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input logic [10:0] c, input logic [1:0] op);
        check({tag, "_st"}, 32'(state_dbg), 32'(st));
        check({tag, "_ctl"}, 32'(ctl), 32'(c));
        check({tag, "_op"}, 32'(alu_op), 32'(op));
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // From FETCH: deliver opcode with mem_ready, pass through DECODE, land in EXEC with opcode removed.
    task automatic fetch_dec(input logic [6:0] opc);
        opcode = opc;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        check("dec_st", 32'(state_dbg), 32'd2);
        tick;
        opcode = 7'h00;
    endtask

    task automatic clear_trap;
        trap_clear = 1'b1;
        tick;
        trap_clear = 1'b0;
        check("clr_st", 32'(state_dbg), 32'd1);
        check("clr_trap", 32'({trap, trap_cause}), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        #1;
        expect_out("rst", 0, '0, 2'b00);
        check("rst_trap", 32'({trap, trap_cause}), 32'd0);
        rst_n = 1'b1;
        tick;
        expect_out("f_wait", 1, F0, 2'b00);
        // R-type, 4 cycles
        opcode = OP_R;
        mem_ready = 1'b1;
        #1 expect_out("f_rdy", 1, F1, 2'b00);
        tick;
        mem_ready = 1'b0;
        expect_out("r_dec", 2, '0, 2'b00);
        tick;
        opcode = 7'h00;
        expect_out("r_exe", 3, '0, 2'b00);
        tick;
        expect_out("r_wb", 5, WB_R, 2'b00);
        tick;
        expect_out("r_f", 1, F0, 2'b00);
        // LOAD with 3 data wait cycles
        fetch_dec(OP_LOAD);
        expect_out("ld_exe", 3, EX_LS, 2'b10);
        tick;
        for (int i = 0; i < 3; i++) begin
            expect_out("ld_mem", 4, MEM_LD, 2'b10);
            tick;
        end
        mem_ready = 1'b1;
        #1 expect_out("ld_mem_r", 4, MEM_LD, 2'b10);
        tick;
        mem_ready = 1'b0;
        expect_out("ld_wb", 5, WB_LD, 2'b00);
        tick;
        check("ld_f", 32'(state_dbg), 32'd1);
        // STORE
        fetch_dec(OP_STORE);
        expect_out("st_exe", 3, EX_LS, 2'b10);
        tick;
        expect_out("st_mem", 4, MEM_ST, 2'b10);
        mem_ready = 1'b1;
        #1 expect_out("st_mem_r", 4, MEM_ST_R, 2'b10);
        tick;
        mem_ready = 1'b0;
        check("st_f", 32'(state_dbg), 32'd1);
        // BRANCH and JAL
        fetch_dec(OP_BRANCH);
        expect_out("br_exe", 3, EX_BR, 2'b01);
        tick;
        check("br_f", 32'(state_dbg), 32'd1);
        fetch_dec(OP_JAL);
        expect_out("jal_exe", 3, EX_JAL, 2'b10);
        tick;
        check("jal_f", 32'(state_dbg), 32'd1);
        // Illegal opcode trap, held through idle cycles
        fetch_dec(OP_BAD);
        expect_out("ill", 6, '0, 2'b00);
        check("ill_trap", 32'({trap, trap_cause}), 32'b101);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("ill_hold", 32'({state_dbg, trap, trap_cause}), 32'b110101);
        end
        clear_trap;
        // Fetch timeout after 16 FETCH cycles
        for (int i = 0; i < 15; i++) tick;
        check("fto_16", 32'(state_dbg), 32'd1);
        tick;
        check("fto_trap", 32'({state_dbg, trap, trap_cause}), 32'b110110);
        clear_trap;
        // Ready on the 16th cycle wins
        for (int i = 0; i < 15; i++) tick;
        opcode = OP_R;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        check("f16_rdy", 32'({state_dbg, trap}), 32'b0100);
        tick;
        tick;
        tick;
        check("f16_back", 32'(state_dbg), 32'd1);
        // Data timeout
        fetch_dec(OP_LOAD);
        tick;
        for (int i = 0; i < 15; i++) tick;
        check("dto_16", 32'(state_dbg), 32'd4);
        tick;
        check("dto_trap", 32'({state_dbg, trap, trap_cause}), 32'b110111);
        clear_trap;
        // Asynchronous reset in the middle of a store
        fetch_dec(OP_STORE);
        tick;
        expect_out("pre_rst", 4, MEM_ST, 2'b10);
        #2 rst_n = 1'b0;
        #1 expect_out("rst_mid", 0, '0, 2'b00);
        check("rst_mid_trap", 32'({trap, trap_cause}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_multicycle_control.md
Name: riscv_multicycle_control

Overview:
Multi-cycle successor to the single-cycle RV32I control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states and handshakes with a shared instruction/data memory port. It also adds illegal-opcode and memory-timeout trapping, and a parametrised ALU-op width. It sits between the instruction register (which supplies opcode) and the datapath muxes, register-file enables and memory port.

Parameters:
ALUOP_W, 2, alu_op width; legal values 2 or 3. When 3, bit 2 = 1 marks an immediate-arithmetic op.
MEM_TIMEOUT, 15, max cycles to wait for mem_ready in FETCH/MEM before trapping; 0 disables the timeout.
TRAP_ON_ILLEGAL, 1, 1 = unknown opcode traps; 0 = unknown opcode is treated as a NOP (goes to WB with reg_write=0).

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]; sampled in DECODE
mem_ready  in  1  memory completes the current request this cycle
trap_clear  in  1  leave TRAP; ignored in any other state
mem_req  out  1  memory request valid
i_or_d  out  1  0 = instruction address (PC), 1 = data address (ALU result)
mem_read  out  1  read strobe
mem_write  out  1  write strobe
ir_write  out  1  load IR from memory read data
pc_write  out  1  unconditional PC update
branch  out  1  PC update qualified by the ALU zero/compare result
jump  out  1  PC takes the jump target
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback source is memory data
alu_src  out  1  ALU operand B is the immediate
alu_op  out  ALUOP_W  00 = arithmetic (R/I), 01 = branch compare, 10 = add (address/LUI/AUIPC/jump)
trap  out  1  sticky trap flag
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = fetch timeout, 11 = data timeout
state_dbg  out  3  current state encoding

Behaviour:
- Reset is asynchronous, active-low, one clock. While rst_n=0:
  - state = IDLE, opcode_q = 0, timeout counter = 0.
  - trap = 0, trap_cause = 00.
  - All outputs are 0.
- Outputs are a pure decode of the registered state and opcode_q; no input-to-output combinational path except mem_ready to ir_write/pc_write qualification.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - Outputs: mem_req=1, mem_read=1, i_or_d=0; ir_write = mem_ready.
  - On mem_ready go to DECODE; otherwise stay.
- DECODE:
  - Registers opcode_q <= opcode.
  - Class is one of R(0110011), I(0010011), LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
  - Illegal opcode with TRAP_ON_ILLEGAL=1: go to TRAP, cause 01. Any other opcode: go to EXEC.
- EXEC:
  - alu_src=1 for LOAD, STORE, I, LUI, AUIPC, JALR.
  - alu_op: R/I = 00 (bit 2 = 1 for I when ALUOP_W=3); BRANCH = 01; all others = 10.
  - BRANCH: branch=1, then go to FETCH.
  - JAL/JALR: jump=1, pc_write=1, reg_write=1 (link = PC+4), then go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - Outputs: mem_req=1, i_or_d=1, alu_src=1, alu_op=10; mem_read=1 for LOAD, mem_write=1 for STORE.
  - Strobes are held until mem_ready.
  - On mem_ready: LOAD goes to WB; STORE asserts pc_write=1 (PC+4) and goes to FETCH.
- WB:
  - reg_write=1, except 0 for an illegal opcode with TRAP_ON_ILLEGAL=0; mem_to_reg=1 for LOAD only; pc_write=1 (PC+4).
  - Next state FETCH.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle spent there without mem_ready.
  - When the counter = MEM_TIMEOUT and mem_ready=0, go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - mem_ready in the same cycle as the limit: ready wins, no trap.
- TRAP:
  - trap=1; all other control outputs 0; trap_cause held.
  - trap_clear=1 goes to FETCH and clears trap and trap_cause.
  - PC is not advanced; recovery is software/debug responsibility.
- mem_ready outside FETCH/MEM is ignored. trap_clear outside TRAP is ignored.
- Reset asserted mid-transaction aborts immediately: mem_req drops to 0 asynchronously; no partial write completes.
- At most one of pc_write/branch is active in any cycle. mem_read and mem_write are never both 1.

Test Plan:
- R-type (opcode 0110011), mem_ready=1 in FETCH -> states 1,2,3,5,1; reg_write=1 only in WB; alu_op=00; 4 cycles per instruction.
- LOAD (0000011), data mem_ready after 3 wait cycles -> MEM holds mem_read=1, i_or_d=1 for 4 cycles, then WB with mem_to_reg=1, reg_write=1; 8 cycles total.
- STORE (0100011) -> mem_write=1 in MEM, reg_write never asserted, pc_write=1 on the mem_ready cycle, returns to FETCH.
- BRANCH (1100011) and JAL (1101111) -> BRANCH: branch=1, alu_op=01 in EXEC, then FETCH; JAL: jump=1, pc_write=1, reg_write=1 in EXEC.
- Illegal opcode 1111111 with TRAP_ON_ILLEGAL=1 -> TRAP, trap=1, cause=01; outputs held through 10 idle cycles; trap_clear -> FETCH, trap=0.
- MEM_TIMEOUT=15, mem_ready never asserted in FETCH -> TRAP cause=10 after 16 FETCH cycles. Repeat with mem_ready on the 16th cycle -> DECODE, no trap. Assert rst_n=0 mid-MEM -> all outputs 0 immediately, IDLE.
